arbiter_rr_16: RTL and testbench
================================

ARBITER_RR_16 -- requirements
Module: arbiter_rr_16

Interface
REQ-001 Parameter TIMEOUT, default 255, SHALL set the maximum grant hold in cycles; 0 disables the timeout.
REQ-002 clk  in  1  SHALL be the single clock; all state updates on its rising edge.
REQ-003 rst  in  1  SHALL be a synchronous, active-high reset.
REQ-004 req  in  [0:15]  SHALL carry request lines; bit 0 is requester 0 (MSB-first ordering).
REQ-005 rel  in  1  SHALL be the release strobe from the current grant holder, sampled only in BUSY.
REQ-006 gnt  out  [0:15]  SHALL be the one-hot grant, bit k for requester k, zero when idle.
REQ-007 gnt_id  out  [0:3]  SHALL be the binary index of the granted requester.
REQ-008 busy  out  1  SHALL be high whenever a grant is held.
REQ-009 tmo  out  1  SHALL pulse high for one cycle when a grant is revoked by timeout.

Function
REQ-010 The FSM SHALL have two states: IDLE and BUSY.
REQ-011 IDLE: if req != 0, the winner SHALL be chosen and registered; gnt, gnt_id and busy SHALL assert in cycle N+1 for req sampled in cycle N; else stay IDLE.
REQ-012 Winner SHALL be the first set req bit searched in order ptr, ptr+1, ..., 15, 0, ..., ptr-1 (mod-16 wrap).
REQ-013 ptr SHALL be 4 bits, reset to 0, and updated to (winner+1) mod 16 when the grant ends; 15+1 wraps to 0.
REQ-014 BUSY: gnt and gnt_id SHALL be held stable regardless of req changes, including the holder dropping req.
REQ-015 BUSY with rel=1 SHALL clear gnt and busy in the next cycle and return to IDLE.
REQ-016 A cycle hold counter SHALL clear on grant and increment every BUSY cycle without rel.
REQ-017 With TIMEOUT>0, when the counter reaches TIMEOUT-1 and rel=0, the grant SHALL be revoked in the next cycle, tmo SHALL pulse in that same cycle, and ptr SHALL advance as for a release.
REQ-018 rel and timeout in the same cycle SHALL be treated as a release; tmo SHALL stay low.
REQ-019 rel in IDLE SHALL be ignored.
REQ-020 Minimum grant-to-grant spacing SHALL be 2 cycles after release: release cycle, then one IDLE arbitration cycle.
REQ-021 gnt_id SHALL retain the last winner after release; it is valid only while busy=1.
REQ-022 gnt SHALL never have more than one bit set.

Reset
REQ-023 rst=1 at a clock edge SHALL force state IDLE, ptr=0, counter=0, gnt=0, gnt_id=0, busy=0, tmo=0.
REQ-024 rst asserted mid-grant SHALL revoke the grant without a tmo pulse; rst SHALL override rel and timeout.
REQ-025 The first arbitration after rst deasserts SHALL occur in the first cycle with rst=0.

Structure
REQ-026 NUM_REQ=16, ID_WIDTH=4, and the IDLE/BUSY state encodings SHALL live in the shared VCPU32 definitions include.
REQ-027 Index generation SHALL instantiate the existing Encoder_16_4 on the one-hot winner vector; the rotate/priority mask, FSM and counter SHALL be local logic.

Verification
REQ-028 Reset, then req=16'h0001 -> next cycle gnt=16'h0001, gnt_id=15, busy=1; rel -> next cycle gnt=0, busy=0, ptr=0.
REQ-029 req=16'hFFFF held, rel pulsed each grant -> gnt_id sequence 0,1,2,...,15,0 with wrap; each grant arrives 2 cycles after rel.
REQ-030 TIMEOUT=4, req=16'h8000, no rel -> busy for 4 cycles, then gnt=0 with tmo=1 for one cycle; the next grant goes to requester 0 again only if no other requester is active.
REQ-031 Grant to requester 3, then req changes to 16'h0000 mid-BUSY -> gnt stays 16'h1000 until rel.
REQ-032 Grant active, rst=1 for one cycle -> gnt=0, busy=0, tmo=0; ptr=0, and req=16'h0101 -> grant to requester 7.
REQ-033 TIMEOUT=4, rel coincident with the timeout cycle -> release, tmo=0; a bench check SHALL confirm gnt is one-hot or zero in every cycle.

Source files
------------

// File: rtl/arbiter_rr_16_pkg.sv
// Shared sizes, FSM encoding and the priority-pick helper for the 16-way round-robin arbiter.
package arbiter_rr_16_pkg;
  localparam int NUM_REQ  = 16;
  localparam int ID_WIDTH = 4;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } state_t;

  // One-hot of the lowest-index set bit (index 0 is requester 0, the MSB).
  function automatic logic [0:NUM_REQ-1] first_set(input logic [0:NUM_REQ-1] v);
    logic [0:NUM_REQ-1] r;
    logic               found;
    r     = '0;
    found = 1'b0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (v[k] && !found) begin
        r[k]  = 1'b1;
        found = 1'b1;
      end
    end
    return r;
  endfunction
endpackage

// File: rtl/arbiter_rr_16_encoder.sv
// One-hot to binary index encoder; bit k of the input maps to index k.
module Encoder_16_4
  import arbiter_rr_16_pkg::*;
(
  input  logic [0:NUM_REQ-1]  i_onehot,
  output logic [0:ID_WIDTH-1] o_idx
);
  always_comb begin
    o_idx = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (i_onehot[k]) o_idx = o_idx | ID_WIDTH'(k);
    end
  end
endmodule

// File: rtl/arbiter_rr_16.sv
// 16-requester round-robin arbiter: grant held until release or timeout,
// pointer moves past the last winner when its grant ends.
module arbiter_rr_16
  import arbiter_rr_16_pkg::*;
#(
  parameter int TIMEOUT = 255
) (
  input  logic                i_clk,
  input  logic                i_rst,
  input  logic [0:NUM_REQ-1]  i_req,
  input  logic                i_rel,
  output logic [0:NUM_REQ-1]  o_gnt,
  output logic [0:ID_WIDTH-1] o_gnt_id,
  output logic                o_busy,
  output logic                o_tmo
);
  localparam int            CW       = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);
  localparam bit            TMO_EN   = (TIMEOUT > 0);

  state_t              r_state, w_state_nxt;
  logic [ID_WIDTH-1:0] r_ptr, w_ptr_nxt, w_ptr_adv;
  logic [CW-1:0]       r_cnt, w_cnt_nxt;
  logic [0:NUM_REQ-1]  r_gnt, w_gnt_nxt, w_hi, w_win;
  logic [0:ID_WIDTH-1] r_gnt_id, w_gnt_id_nxt, w_win_id;
  logic                r_tmo, w_tmo_nxt;

  // Requests at or above ptr take priority; otherwise wrap to the lowest index.
  always_comb begin
    w_hi = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      w_hi[k] = i_req[k] && (ID_WIDTH'(k) >= r_ptr);
    end
  end

  assign w_win     = (|w_hi) ? first_set(w_hi) : first_set(i_req);
  assign w_ptr_adv = r_gnt_id + 1'b1;

  Encoder_16_4 u_enc (
    .i_onehot (w_win),
    .o_idx    (w_win_id)
  );

  always_comb begin
    w_state_nxt  = r_state;
    w_gnt_nxt    = r_gnt;
    w_gnt_id_nxt = r_gnt_id;
    w_ptr_nxt    = r_ptr;
    w_cnt_nxt    = r_cnt;
    w_tmo_nxt    = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (|i_req) begin
          w_state_nxt  = ST_BUSY;
          w_gnt_nxt    = w_win;
          w_gnt_id_nxt = w_win_id;
          w_cnt_nxt    = '0;
        end
      end
      ST_BUSY: begin
        // Release wins over a coinciding timeout, so tmo stays low then.
        if (i_rel) begin
          w_state_nxt = ST_IDLE;
          w_gnt_nxt   = '0;
          w_ptr_nxt   = w_ptr_adv;
          w_cnt_nxt   = '0;
        end else if (TMO_EN && (r_cnt == CNT_LAST)) begin
          w_state_nxt = ST_IDLE;
          w_gnt_nxt   = '0;
          w_ptr_nxt   = w_ptr_adv;
          w_cnt_nxt   = '0;
          w_tmo_nxt   = 1'b1;
        end else begin
          w_cnt_nxt = r_cnt + 1'b1;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state  <= ST_IDLE;
      r_gnt    <= '0;
      r_gnt_id <= '0;
      r_ptr    <= '0;
      r_cnt    <= '0;
      r_tmo    <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_gnt    <= w_gnt_nxt;
      r_gnt_id <= w_gnt_id_nxt;
      r_ptr    <= w_ptr_nxt;
      r_cnt    <= w_cnt_nxt;
      r_tmo    <= w_tmo_nxt;
    end
  end

  assign o_gnt    = r_gnt;
  assign o_gnt_id = r_gnt_id;
  assign o_busy   = (r_state == ST_BUSY);
  assign o_tmo    = r_tmo;
endmodule

// File: tb/tb_arbiter_rr_16.sv
// Scoreboard bench for arbiter_rr_16 built with TIMEOUT=4.
module tb_arbiter_rr_16;
  typedef struct packed {
    logic [15:0] gnt;
    logic [3:0]  id;
    logic        busy;
    logic        tmo;
  } obs_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        rel = 1'b0;
  logic [0:15] req = '0;
  logic [0:15] gnt;
  logic [0:3]  gnt_id;
  logic        busy, tmo;

  int   checks   = 0;
  int   failures = 0;
  obs_t exp_q[$];
  obs_t obs_q[$];

  arbiter_rr_16 #(.TIMEOUT(4)) dut (
    .i_clk    (clk),
    .i_rst    (rst),
    .i_req    (req),
    .i_rel    (rel),
    .o_gnt    (gnt),
    .o_gnt_id (gnt_id),
    .o_busy   (busy),
    .o_tmo    (tmo)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] oh(input int k);
    return 16'h8000 >> k;
  endfunction

  // Drive one cycle, queue what the outputs must be after the edge, sample them.
  task automatic step(input logic r, input logic [15:0] rq, input logic rl,
                      input logic [15:0] eg, input int eid, input logic eb, input logic et);
    obs_t e, o;
    rst = r; req = rq; rel = rl;
    e = '{gnt: eg, id: 4'(eid), busy: eb, tmo: et};
    exp_q.push_back(e);
    @(posedge clk); #1;
    o = '{gnt: gnt, id: gnt_id, busy: busy, tmo: tmo};
    obs_q.push_back(o);
  endtask

  task automatic test_reset();
    obs_t e, o;
    int n = 0;
    step(1, 16'hFFFF, 1, 16'h0000, 0, 0, 0);
    step(1, 16'h0001, 0, 16'h0000, 0, 0, 0);
    while (exp_q.size() != 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); n++;
      checks++;
      if (o !== e) begin
        failures++;
        $display("FAIL reset step%0d: got gnt=%h id=%0d busy=%b tmo=%b expected gnt=%h id=%0d busy=%b tmo=%b",
                 n, o.gnt, o.id, o.busy, o.tmo, e.gnt, e.id, e.busy, e.tmo);
      end
      checks++;
      if (!$onehot0(o.gnt)) begin failures++; $display("FAIL reset_onehot step%0d: got gnt=%h required one-hot or zero", n, o.gnt); end
    end
  endtask

  task automatic test_basic();
    obs_t e, o;
    int n = 0;
    step(1, 16'h0000, 0, 16'h0000, 0, 0, 0);
    step(0, 16'h0001, 0, 16'h0001, 15, 1, 0);
    step(0, 16'h0000, 1, 16'h0000, 15, 0, 0);
    step(0, 16'h8001, 0, 16'h8000, 0, 1, 0);   // ptr wrapped to 0
    step(0, 16'h0000, 1, 16'h0000, 0, 0, 0);
    step(0, 16'h0000, 1, 16'h0000, 0, 0, 0);   // rel in IDLE ignored
    while (exp_q.size() != 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); n++;
      checks++;
      if (o !== e) begin
        failures++;
        $display("FAIL basic step%0d: got gnt=%h id=%0d busy=%b tmo=%b expected gnt=%h id=%0d busy=%b tmo=%b",
                 n, o.gnt, o.id, o.busy, o.tmo, e.gnt, e.id, e.busy, e.tmo);
      end
      checks++;
      if (!$onehot0(o.gnt)) begin failures++; $display("FAIL basic_onehot step%0d: got gnt=%h required one-hot or zero", n, o.gnt); end
    end
  endtask

  task automatic test_round_robin();
    obs_t e, o;
    int n = 0;
    step(1, 16'h0000, 0, 16'h0000, 0, 0, 0);
    step(0, 16'hFFFF, 0, oh(0), 0, 1, 0);
    for (int i = 0; i < 16; i++) begin
      step(0, 16'hFFFF, 1, 16'h0000, i, 0, 0);
      step(0, 16'hFFFF, logic'(i % 3 == 0), oh((i + 1) % 16), (i + 1) % 16, 1, 0);
    end
    step(0, 16'h0000, 1, 16'h0000, 0, 0, 0);
    while (exp_q.size() != 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); n++;
      checks++;
      if (o !== e) begin
        failures++;
        $display("FAIL rr step%0d: got gnt=%h id=%0d busy=%b tmo=%b expected gnt=%h id=%0d busy=%b tmo=%b",
                 n, o.gnt, o.id, o.busy, o.tmo, e.gnt, e.id, e.busy, e.tmo);
      end
      checks++;
      if (!$onehot0(o.gnt)) begin failures++; $display("FAIL rr_onehot step%0d: got gnt=%h required one-hot or zero", n, o.gnt); end
    end
  endtask

  task automatic test_timeout();
    obs_t e, o;
    int n = 0;
    step(1, 16'h0000, 0, 16'h0000, 0, 0, 0);
    for (int r = 0; r < 2; r++) begin
      for (int c = 0; c < 4; c++) step(0, 16'h8000, 0, 16'h8000, 0, 1, 0);
      step(0, (r == 0) ? 16'h8000 : 16'hC000, 0, 16'h0000, 0, 0, 1);
    end
    step(0, 16'hC000, 0, 16'h4000, 1, 1, 0);   // ptr=1 after timeout
    step(0, 16'h0000, 1, 16'h0000, 1, 0, 0);
    while (exp_q.size() != 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); n++;
      checks++;
      if (o !== e) begin
        failures++;
        $display("FAIL timeout step%0d: got gnt=%h id=%0d busy=%b tmo=%b expected gnt=%h id=%0d busy=%b tmo=%b",
                 n, o.gnt, o.id, o.busy, o.tmo, e.gnt, e.id, e.busy, e.tmo);
      end
      checks++;
      if (!$onehot0(o.gnt)) begin failures++; $display("FAIL timeout_onehot step%0d: got gnt=%h required one-hot or zero", n, o.gnt); end
    end
  endtask

  task automatic test_hold_and_coincident_rel();
    obs_t e, o;
    int n = 0;
    step(1, 16'h0000, 0, 16'h0000, 0, 0, 0);
    step(0, 16'h1000, 0, 16'h1000, 3, 1, 0);
    step(0, 16'h0000, 0, 16'h1000, 3, 1, 0);
    step(0, 16'h0000, 0, 16'h1000, 3, 1, 0);
    step(0, 16'hFFFF, 0, 16'h1000, 3, 1, 0);
    step(0, 16'hFFFF, 1, 16'h0000, 3, 0, 0);   // rel on the timeout cycle
    step(0, 16'hFFFF, 0, 16'h0800, 4, 1, 0);
    step(0, 16'h0000, 1, 16'h0000, 4, 0, 0);
    while (exp_q.size() != 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); n++;
      checks++;
      if (o !== e) begin
        failures++;
        $display("FAIL hold step%0d: got gnt=%h id=%0d busy=%b tmo=%b expected gnt=%h id=%0d busy=%b tmo=%b",
                 n, o.gnt, o.id, o.busy, o.tmo, e.gnt, e.id, e.busy, e.tmo);
      end
      checks++;
      if (!$onehot0(o.gnt)) begin failures++; $display("FAIL hold_onehot step%0d: got gnt=%h required one-hot or zero", n, o.gnt); end
    end
  endtask

  task automatic test_reset_mid_grant();
    obs_t e, o;
    int n = 0;
    step(1, 16'h0000, 0, 16'h0000, 0, 0, 0);
    step(0, 16'h0002, 0, 16'h0002, 14, 1, 0);
    for (int c = 0; c < 3; c++) step(0, 16'h0002, 0, 16'h0002, 14, 1, 0);
    step(1, 16'h0002, 1, 16'h0000, 0, 0, 0);   // rst beats rel and timeout
    step(0, 16'h0101, 0, 16'h0100, 7, 1, 0);
    step(0, 16'h0000, 1, 16'h0000, 7, 0, 0);
    while (exp_q.size() != 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); n++;
      checks++;
      if (o !== e) begin
        failures++;
        $display("FAIL rst_mid step%0d: got gnt=%h id=%0d busy=%b tmo=%b expected gnt=%h id=%0d busy=%b tmo=%b",
                 n, o.gnt, o.id, o.busy, o.tmo, e.gnt, e.id, e.busy, e.tmo);
      end
      checks++;
      if (!$onehot0(o.gnt)) begin failures++; $display("FAIL rst_mid_onehot step%0d: got gnt=%h required one-hot or zero", n, o.gnt); end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_round_robin();
    test_timeout();
    test_hold_and_coincident_rel();
    test_reset_mid_grant();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
